// File: rtl/bcd_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer_ctrl_if
//  Description : Front-panel / display-side signal bundle for the BCD timer
//                run controller. The panel logic holds the master end, the
//                controller holds the slave end.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_timer_ctrl_if #(
    parameter int DIGITS = 4
) ();
    logic                  start;
    logic                  stop;
    logic                  load_req;
    logic                  mode;
    logic [4*DIGITS-1:0]   preset;
    logic [4*DIGITS-1:0]   q;
    logic [DIGITS-1:0]     dig_en;
    logic [1:0]            state;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stop, load_req, mode, preset,
        input  q, dig_en, state, busy, done
    );

    modport slave (
        input  start, stop, load_req, mode, preset,
        output q, dig_en, state, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer_ctrl
//  Description : Run controller for a chain of cascaded BCD digits used as a
//                countdown timer (mode=0) or up-counting stopwatch (mode=1).
//                Generates the prescaled tick, the rippled per-digit enables,
//                preset loading, start/pause/stop and terminal detection.
//  Options     : BCD_TIMER_AUTO_RELOAD_EN - on terminal, reload and keep
//                running; done becomes a one-cycle pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1000
) (
    input  logic              clkin,
    input  logic              clr,
    bcd_timer_ctrl_if.slave   bus
);
    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int            QW       = 4 * DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   count_q, count_d;
    logic [PW-1:0]   pre_q,   pre_d;
    logic            done_q,  done_d;

    logic [QW-1:0]     preset_sat;
    logic [QW-1:0]     reload_val;
    logic [QW-1:0]     target_val;
    logic [QW-1:0]     count_step;
    logic [DIGITS-1:0] carry_en;
    logic              tick;
    logic              at_target;
    logic              step;
    logic              hit_target;

    // Clamp every preset digit above 9 down to 9; used for both loading and comparing.
    always_comb begin
        preset_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            preset_sat[4*i +: 4] = (bus.preset[4*i +: 4] > 4'd9) ? 4'd9 : bus.preset[4*i +: 4];
        end
    end

    // Down-count starts from the preset and ends at zero; up-count is the reverse.
    assign reload_val = bus.mode ? '0 : preset_sat;
    assign target_val = bus.mode ? preset_sat : '0;

    // Ripple the carry (up) or borrow (down) enable through the chain and form the stepped count.
    always_comb begin
        logic       ripple;
        logic [3:0] digit;
        ripple     = 1'b1;
        digit      = 4'd0;
        carry_en   = '0;
        count_step = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            digit       = count_q[4*i +: 4];
            carry_en[i] = ripple;
            if (ripple) begin
                if (bus.mode) begin
                    count_step[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
                end else begin
                    count_step[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
                end
            end
            ripple = ripple && (digit == (bus.mode ? 4'd9 : 4'd0));
        end
    end

    // A tick only counts in RUN when neither stop nor load_req overrides it this cycle.
    // If the count already sits on its target, the tick terminates without stepping,
    // so no digit is strobed (no borrow from 0 to 9, no step past an up target of 0).
    assign tick       = (state_q == S_RUN) && !bus.stop && !bus.load_req && (pre_q == PRE_LAST);
    assign at_target  = (count_q == target_val);
    assign step       = tick && !at_target;
    assign hit_target = tick && (at_target || (count_step == target_val));

    // Next-state, count, prescaler and done flag, in priority order load_req first.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        done_d  = 1'b0;
`else
        done_d  = done_q;
`endif
        if (bus.load_req) begin
            count_d = reload_val;
            state_d = S_IDLE;
            done_d  = 1'b0;
            pre_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        // Prescaler phase is frozen here so resume keeps it.
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        if (step) begin
                            count_d = count_step;
                        end
                        if (hit_target) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                            count_d = reload_val;
                            done_d  = 1'b1;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    // Re-arm: reload as a load_req would, and go straight to RUN.
                    if (bus.start) begin
                        count_d = reload_val;
                        pre_d   = '0;
                        done_d  = 1'b0;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, count, prescaler and done registers with asynchronous active-low clear.
    always_ff @(posedge clkin or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    assign bus.q      = count_q;
    assign bus.dig_en = step ? carry_en : '0;
    assign bus.state  = state_q;
    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = done_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_timer_ctrl
//  Description : Self-checking bench for bcd_timer_ctrl. A decimal-integer
//                reference model predicts every output each cycle; directed
//                scenarios add hand-computed expectations, followed by
//                randomized panel activity.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_timer_ctrl;
    localparam int DIGITS = 4;
    localparam int TD     = 2;
    localparam int QW     = 4 * DIGITS;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_DONE  = 3;

    logic clkin = 1'b0;
    logic clr   = 1'b1;

    bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_timer_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TD)
    ) dut (
        .clkin (clkin),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        int val;   // count as a plain decimal integer
        int pre;   // cycles elapsed in the current tick period
        int st;
        bit done;
    } mstate_t;

    mstate_t m = '{0, 0, 0, 1'b0};

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int sat_int(logic [QW-1:0] p);
        int r = 0;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(p[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [QW-1:0] to_bcd(int v);
        logic [QW-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int next_val(int v, bit up);
        return up ? (v + 1) % pow10(DIGITS) : v - 1;
    endfunction

    // Enabled digits are exactly those whose decimal digit changes on the step.
    function automatic logic [DIGITS-1:0] exp_dig_en(mstate_t c, bit stop, bit load, bit up,
                                                     logic [QW-1:0] preset);
        logic [DIGITS-1:0] r = '0;
        int tgt = up ? sat_int(preset) : 0;
        if (c.st == ST_RUN && !stop && !load && c.pre == TD - 1 && c.val != tgt) begin
            int nv = next_val(c.val, up);
            for (int i = 0; i < DIGITS; i++)
                r[i] = ((c.val / pow10(i)) % 10) != ((nv / pow10(i)) % 10);
        end
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t c, bit start, bit stop, bit load, bit up,
                                           logic [QW-1:0] preset);
        mstate_t n = c;
        int tgt = up ? sat_int(preset) : 0;
        int rel = up ? 0 : sat_int(preset);
        bit hit = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        n.done = 1'b0;
`endif
        if (load) begin
            n.val = rel; n.st = ST_IDLE; n.done = 1'b0; n.pre = 0;
        end else if (c.st == ST_IDLE) begin
            if (start) n.st = ST_RUN;
        end else if (c.st == ST_RUN) begin
            if (stop) begin
                n.st = ST_PAUSE;
            end else if (c.pre == TD - 1) begin
                n.pre = 0;
                if (c.val == tgt) begin
                    hit = 1'b1;
                end else begin
                    n.val = next_val(c.val, up);
                    hit = (n.val == tgt);
                end
                if (hit) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    n.val = rel; n.done = 1'b1;
`else
                    n.st = ST_DONE; n.done = 1'b1;
`endif
                end
            end else begin
                n.pre = c.pre + 1;
            end
        end else if (c.st == ST_PAUSE) begin
            if (start && !stop) n.st = ST_RUN;
        end else begin
            if (start) begin
                n.val = rel; n.st = ST_RUN; n.done = 1'b0; n.pre = 0;
            end
        end
        return n;
    endfunction

    // Reference model advances on the same edges as the DUT, cleared asynchronously.
    always @(posedge clkin or negedge clr) begin
        if (!clr) m <= '{0, 0, 0, 1'b0};
        else      m <= model_next(m, bus.start, bus.stop, bus.load_req, bus.mode, bus.preset);
    end

    // Compare every output against the model a little after each falling edge.
    always @(negedge clkin) begin : cmp
        logic [QW-1:0]     eq;
        logic [DIGITS-1:0] een;
        logic [1:0]        est;
        logic              ebusy;
        logic              edone;
        #2;
        if (chk_en) begin
            eq    = to_bcd(m.val);
            een   = exp_dig_en(m, bus.stop, bus.load_req, bus.mode, bus.preset);
            est   = 2'(m.st);
            ebusy = (m.st == ST_RUN);
            edone = m.done;
            n_checks++;
            if ({bus.q, bus.dig_en, bus.state, bus.busy, bus.done} !== {eq, een, est, ebusy, edone}) begin
                n_errors++;
                $display("FAIL cycle_cmp t=%0t: q=%h en=%b st=%0d busy=%b done=%b, expected q=%h en=%b st=%0d busy=%b done=%b",
                         $time, bus.q, bus.dig_en, bus.state, bus.busy, bus.done, eq, een, est, ebusy, edone);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input bit md, input logic [QW-1:0] p);
        @(negedge clkin);
        bus.mode = md; bus.preset = p; bus.load_req = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
        @(negedge clkin);
        bus.load_req = 1'b0;
        #3;
    endtask

    function automatic logic [QW-1:0] rand_preset();
        logic [QW-1:0] p = '0;
        p[3:0] = 4'($urandom_range(0, 15));
        p[7:4] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) p[11:8]  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) p[15:12] = 4'($urandom_range(0, 2));
        return p;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        bus.start = 1'b0; bus.stop = 1'b0; bus.load_req = 1'b0; bus.mode = 1'b0; bus.preset = '0;
        #1 clr = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clkin); #3;
        lit("rst_q", bus.q, 0);
        lit("rst_state", bus.state, 0);
        @(negedge clkin); clr = 1'b1;

        // Countdown 3,2,1,0 with a tick every 2 cycles.
        load(1'b0, 16'h0003);
        lit("t1_load_q", bus.q, 16'h0003);
        bus.start = 1'b1;
        @(negedge clkin); bus.start = 1'b0; #3;
        lit("t1_run_state", bus.state, ST_RUN);
        @(negedge clkin); #3;
        lit("t1_tick_en", bus.dig_en, 4'b0001);
        @(negedge clkin); #3;
        lit("t1_q2", bus.q, 16'h0002);
        repeat (4) @(negedge clkin);
        #3;
        lit("t1_done_flag", bus.done, 1);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        lit("t1_reload_q", bus.q, 16'h0003);
        lit("t1_stay_run", bus.state, ST_RUN);
`else
        lit("t1_q0", bus.q, 16'h0000);
        lit("t1_done_state", bus.state, ST_DONE);
        repeat (3) @(negedge clkin);
        #3;
        lit("t1_hold_q", bus.q, 16'h0000);
        lit("t1_hold_en", bus.dig_en, 0);
`endif

        // Borrow ripple 0100 -> 0099.
        load(1'b0, 16'h0100);
        lit("t2_done_clr", bus.done, 0);
        lit("t2_idle", bus.state, ST_IDLE);
        bus.start = 1'b1;
        @(negedge clkin); bus.start = 1'b0;
        @(negedge clkin); #3;
        lit("t2_ripple_en", bus.dig_en, 4'b0111);
        @(negedge clkin); #3;
        lit("t2_q", bus.q, 16'h0099);

        // Stopwatch up to 0012.
        load(1'b1, 16'h0012);
        lit("t3_load_zero", bus.q, 16'h0000);
        bus.start = 1'b1;
        @(negedge clkin); bus.start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clkin); #3;
            if (bus.q == 16'h0009 && bus.dig_en != 0) found = 1'b1;
        end
        lit("t3_reach_9", found, 1);
        lit("t3_carry_en", bus.dig_en, 4'b0011);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clkin); #3;
            if (bus.done) found = 1'b1;
        end
        lit("t3_reach_done", found, 1);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        lit("t3_reload_q", bus.q, 16'h0000);
`else
        lit("t3_final_q", bus.q, 16'h0012);
        lit("t3_done_state", bus.state, ST_DONE);
        bus.start = 1'b1;
        @(negedge clkin); bus.start = 1'b0; #3;
        lit("t3_rearm_q", bus.q, 16'h0000);
        lit("t3_rearm_state", bus.state, ST_RUN);
        lit("t3_rearm_done", bus.done, 0);
`endif

        // Stop and start together on a tick cycle: pause wins, phase is held.
        load(1'b0, 16'h0005);
        bus.start = 1'b1;
        @(negedge clkin); bus.start = 1'b0;
        @(negedge clkin); bus.start = 1'b1; bus.stop = 1'b1; #3;
        lit("t4_stop_no_tick", bus.dig_en, 0);
        repeat (10) @(negedge clkin);
        #3;
        lit("t4_pause_q", bus.q, 16'h0005);
        lit("t4_pause_state", bus.state, ST_PAUSE);
        bus.stop = 1'b0;
        @(negedge clkin); bus.start = 1'b0; #3;
        lit("t4_resume_state", bus.state, ST_RUN);
        lit("t4_resume_tick", bus.dig_en, 4'b0001);
        @(negedge clkin); #3;
        lit("t4_resume_q", bus.q, 16'h0004);

        // Preset digit sanitising and asynchronous clear mid-count.
        load(1'b0, 16'h00A7);
        lit("t5_sanitised", bus.q, 16'h0097);
        bus.start = 1'b1;
        @(negedge clkin); bus.start = 1'b0;
        repeat (5) @(negedge clkin);
        clr = 1'b0; #3;
        lit("t5_clr_q", bus.q, 0);
        lit("t5_clr_state", bus.state, ST_IDLE);
        lit("t5_clr_done", bus.done, 0);
        @(negedge clkin); clr = 1'b1;

        // Randomized panel activity.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clkin);
            clr          = ($urandom_range(0, 299) != 0);
            bus.load_req = ($urandom_range(0, 149) == 0);
            bus.start    = ($urandom_range(0, 5) == 0);
            bus.stop     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 29) == 0 || bus.load_req) bus.preset = rand_preset();
        end

        @(negedge clkin);
        clr = 1'b1; bus.load_req = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        repeat (3) @(negedge clkin);
        #4 chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
